// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down event counter with prescaler, parallel load and wrap/saturate limits.
// Feeds the 7-segment path directly and reports range-limit events to the timer FSM.
module bcd_counter_n #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Init,
    input  logic                  E,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Carry,
    output logic                  Overflow,
    output logic                  Zero
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  bcd_d, inc_val, dec_val, clamp_val;
    logic          carry_d, ovf_d;
    logic          all_nines, all_zeros, boundary;
    logic [3:0]    d_cur, d_ld;
    logic          c_chain, b_chain;

    // Per-digit increment, decrement and load clamp, all resolved in one cycle.
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        c_chain   = 1'b1;
        b_chain   = 1'b1;
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        d_cur     = '0;
        d_ld      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d_cur = BCD[4*k +: 4];
            d_ld  = LoadVal[4*k +: 4];
            inc_val[4*k +: 4]   = c_chain ? ((d_cur == 4'd9) ? 4'd0 : d_cur + 4'd1) : d_cur;
            dec_val[4*k +: 4]   = b_chain ? ((d_cur == 4'd0) ? 4'd9 : d_cur - 4'd1) : d_cur;
            clamp_val[4*k +: 4] = (d_ld > 4'd9) ? 4'd9 : d_ld;
            c_chain = c_chain & (d_cur == 4'd9);
            b_chain = b_chain & (d_cur == 4'd0);
        end
        all_nines = c_chain;
        all_zeros = b_chain;
    end

    assign boundary = Up ? all_nines : all_zeros;

    always_comb begin
        pre_d   = pre_q;
        bcd_d   = BCD;
        carry_d = 1'b0;
        ovf_d   = Overflow;
        if (Init) begin
            pre_d = '0;
            bcd_d = '0;
            ovf_d = 1'b0;
        end else if (Load) begin
            pre_d = '0;
            bcd_d = clamp_val;
            ovf_d = 1'b0;
        end else if (E) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                // Wrapping falls out of the digit arithmetic; saturation just holds.
                if (boundary) begin
                    carry_d = 1'b1;
                    ovf_d   = 1'b1;
                end
                if (!(boundary && SATURATE != 0))
                    bcd_d = Up ? inc_val : dec_val;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pre_q    <= '0;
            BCD      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            pre_q    <= pre_d;
            BCD      <= bcd_d;
            Carry    <= carry_d;
            Overflow <= ovf_d;
            Zero     <= (bcd_d == '0);
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench: three bcd_counter_n instances (wrap, saturate, prescale-10) share stimulus
// and are compared against an integer-valued behavioural model.
module tb_bcd_counter_n;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Init  = 1'b0;
    logic        E     = 1'b0;
    logic        Up    = 1'b1;
    logic        Load  = 1'b0;
    logic [15:0] LoadVal = '0;

    wire [15:0] bcd_w   [3];
    wire        carry_w [3];
    wire        ovf_w   [3];
    wire        zero_w  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int P_PRE [3] = '{1, 1, 10};
    localparam bit P_SAT [3] = '{1'b0, 1'b1, 1'b0};

    always #5 Clock = ~Clock;

    bcd_counter_n #(.DIGITS(4), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .Clock(Clock), .Clear(Clear), .Init(Init), .E(E), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .BCD(bcd_w[0]), .Carry(carry_w[0]), .Overflow(ovf_w[0]), .Zero(zero_w[0]));
    bcd_counter_n #(.DIGITS(4), .PRESCALE(1), .SATURATE(1)) u_sat (
        .Clock(Clock), .Clear(Clear), .Init(Init), .E(E), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .BCD(bcd_w[1]), .Carry(carry_w[1]), .Overflow(ovf_w[1]), .Zero(zero_w[1]));
    bcd_counter_n #(.DIGITS(4), .PRESCALE(10), .SATURATE(0)) u_pre (
        .Clock(Clock), .Clear(Clear), .Init(Init), .E(E), .Up(Up), .Load(Load), .LoadVal(LoadVal),
        .BCD(bcd_w[2]), .Carry(carry_w[2]), .Overflow(ovf_w[2]), .Zero(zero_w[2]));

    // Reference model: the count is a plain integer 0..9999.
    typedef struct {
        int val;
        int pre;
        bit carry;
        bit ovf;
    } model_t;

    model_t m [3];

    function automatic model_t model_next(model_t cur, int np, bit sat, bit init, bit load,
                                          bit en, bit up, logic [15:0] lv);
        model_t n;
        int nib;
        n = cur;
        n.carry = 1'b0;
        if (init) begin
            n = '{0, 0, 1'b0, 1'b0};
        end else if (load) begin
            n.val = 0;
            for (int k = 3; k >= 0; k--) begin
                nib = int'(lv[4*k +: 4]);
                if (nib > 9) nib = 9;
                n.val = n.val * 10 + nib;
            end
            n.pre = 0;
            n.ovf = 1'b0;
        end else if (en) begin
            if (cur.pre == np - 1) begin
                n.pre = 0;
                if ((up && cur.val == 9999) || (!up && cur.val == 0)) begin
                    n.carry = 1'b1;
                    n.ovf   = 1'b1;
                    if (!sat) n.val = up ? 0 : 9999;
                end else begin
                    n.val = up ? cur.val + 1 : cur.val - 1;
                end
            end else begin
                n.pre = cur.pre + 1;
            end
        end
        return n;
    endfunction

    always @(posedge Clock or posedge Clear) begin
        for (int i = 0; i < 3; i++) begin
            if (Clear) m[i] <= '{0, 0, 1'b0, 1'b0};
            else       m[i] <= model_next(m[i], P_PRE[i], P_SAT[i], Init, Load, E, Up, LoadVal);
        end
    end

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int rest;
        r = '0;
        rest = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return r;
    endfunction

    function automatic logic [18:0] snap(int i);
        return {bcd_w[i], carry_w[i], ovf_w[i], zero_w[i]};
    endfunction

    function automatic logic [18:0] msnap(int i);
        return {to_bcd(m[i].val), m[i].carry, m[i].ovf, (m[i].val == 0)};
    endfunction

    function automatic string st(logic [18:0] v);
        return $sformatf("bcd=%h carry=%b ovf=%b zero=%b", v[18:3], v[2], v[1], v[0]);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        logic [18:0] obs, exp;
        #12;
        exp = {16'h0000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            obs = snap(i);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s want %s", i, st(obs), st(exp));
            end
        end
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    task automatic test_wrap();
        logic [18:0] obs, exp;
        logic [15:0] want [4] = '{16'h9998, 16'h9999, 16'h0000, 16'h0001};
        logic        wc   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        wo   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        Load = 1'b1; LoadVal = 16'h9998; E = 1'b0;
        tick();
        Load = 1'b0; E = 1'b1; Up = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) tick();
            exp = {want[s], wc[s], wo[s], (want[s] == 16'h0000)};
            obs = snap(0);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL wrap_up step%0d: got %s want %s", s, st(obs), st(exp));
            end
        end
        E = 1'b0; Load = 1'b1; LoadVal = 16'h0199; tick();
        Load = 1'b0; E = 1'b1; tick();
        exp = {16'h0200, 1'b0, 1'b0, 1'b0}; obs = snap(0); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL up_0199: got %s want %s", st(obs), st(exp)); end
        E = 1'b0; Load = 1'b1; LoadVal = 16'h1000; tick();
        Load = 1'b0; E = 1'b1; Up = 1'b0; tick();
        exp = {16'h0999, 1'b0, 1'b0, 1'b0}; obs = snap(0); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL down_1000: got %s want %s", st(obs), st(exp)); end
        tick();
        exp = {16'h0998, 1'b0, 1'b0, 1'b0}; obs = snap(0); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL down_0999: got %s want %s", st(obs), st(exp)); end
        E = 1'b0; Load = 1'b1; LoadVal = 16'h0000; tick();
        Load = 1'b0; E = 1'b1; tick();
        exp = {16'h9999, 1'b1, 1'b1, 1'b0}; obs = snap(0); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL down_wrap: got %s want %s", st(obs), st(exp)); end
        E = 1'b0; Up = 1'b1;
    endtask

    task automatic test_saturate();
        logic [18:0] obs, exp;
        Load = 1'b1; LoadVal = 16'h9999; tick();
        Load = 1'b0; E = 1'b1; Up = 1'b1;
        exp = {16'h9999, 1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 3; s++) begin
            tick();
            obs = snap(1); n_cmp++;
            if (obs !== exp) begin n_fail++; $display("FAIL sat_up step%0d: got %s want %s", s, st(obs), st(exp)); end
        end
        E = 1'b0; Load = 1'b1; LoadVal = 16'h0000; tick();
        Load = 1'b0; E = 1'b1; Up = 1'b0; tick();
        exp = {16'h0000, 1'b1, 1'b1, 1'b1}; obs = snap(1); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL sat_down: got %s want %s", st(obs), st(exp)); end
        E = 1'b0; tick();
        exp = {16'h0000, 1'b0, 1'b1, 1'b1}; obs = snap(1); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL sat_idle: got %s want %s", st(obs), st(exp)); end
        Up = 1'b1;
    endtask

    task automatic test_prescale();
        logic [18:0] obs, exp;
        Init = 1'b1; tick();
        Init = 1'b0; E = 1'b1; Up = 1'b1; tick(25);
        exp = {16'h0002, 1'b0, 1'b0, 1'b0}; obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL pre_25: got %s want %s", st(obs), st(exp)); end
        E = 1'b0; tick(5);
        E = 1'b1; tick(4);
        obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL pre_29: got %s want %s", st(obs), st(exp)); end
        tick();
        exp = {16'h0003, 1'b0, 1'b0, 1'b0}; obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL pre_30: got %s want %s", st(obs), st(exp)); end
        E = 1'b0;
    endtask

    task automatic test_priority();
        logic [18:0] obs, exp;
        Load = 1'b1; LoadVal = 16'h9999; tick();
        Load = 1'b0; E = 1'b1; Up = 1'b1; tick();
        Init = 1'b1; Load = 1'b1; LoadVal = 16'h1234; tick();
        exp = {16'h0000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            obs = snap(i); n_cmp++;
            if (obs !== exp) begin n_fail++; $display("FAIL init_prio[%0d]: got %s want %s", i, st(obs), st(exp)); end
        end
        Init = 1'b0; E = 1'b0; LoadVal = 16'h9999; tick();
        Load = 1'b0; E = 1'b1; tick();
        Load = 1'b1; LoadVal = 16'hA5F3; tick();
        exp = {16'h9593, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i += 2) begin
            obs = snap(i); n_cmp++;
            if (obs !== exp) begin n_fail++; $display("FAIL load_clamp[%0d]: got %s want %s", i, st(obs), st(exp)); end
        end
        Load = 1'b0; tick();
        exp = {16'h9594, 1'b0, 1'b0, 1'b0}; obs = snap(0); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL after_load: got %s want %s", st(obs), st(exp)); end
        E = 1'b0;
    endtask

    task automatic test_async_clear();
        logic [18:0] obs, exp;
        Load = 1'b1; LoadVal = 16'h0457; E = 1'b0; tick();
        Load = 1'b0; E = 1'b1; Up = 1'b1; tick(3);
        exp = {16'h0457, 1'b0, 1'b0, 1'b0}; obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL pre_midcount: got %s want %s", st(obs), st(exp)); end
        #2 Clear = 1'b1;
        #1;
        exp = {16'h0000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i += 2) begin
            obs = snap(i); n_cmp++;
            if (obs !== exp) begin n_fail++; $display("FAIL async_clear[%0d]: got %s want %s", i, st(obs), st(exp)); end
        end
        E = 1'b0;
        #1 Clear = 1'b0;
        @(negedge Clock);
        E = 1'b1; tick(9);
        obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL clear_9e: got %s want %s", st(obs), st(exp)); end
        tick();
        exp = {16'h0001, 1'b0, 1'b0, 1'b0}; obs = snap(2); n_cmp++;
        if (obs !== exp) begin n_fail++; $display("FAIL clear_10e: got %s want %s", st(obs), st(exp)); end
        E = 1'b0;
    endtask

    task automatic test_random();
        logic [18:0] obs, exp;
        logic [15:0] picks [4] = '{16'h9999, 16'h0000, 16'h9998, 16'h0001};
        Init = 1'b1; tick();
        for (int c = 0; c < 400; c++) begin
            Init = ($urandom_range(31) == 0);
            Load = ($urandom_range(15) == 0);
            E    = ($urandom_range(3) != 0);
            Up   = $urandom_range(1) != 0;
            if ($urandom_range(1) != 0) LoadVal = 16'($urandom);
            else                        LoadVal = picks[$urandom_range(3)];
            tick();
            for (int i = 0; i < 3; i++) begin
                obs = snap(i);
                exp = msnap(i);
                n_cmp++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d] cycle %0d: got %s want %s", i, c, st(obs), st(exp));
                end
            end
        end
        Init = 1'b0; Load = 1'b0; E = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_prescale();
        test_priority();
        test_async_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised N-digit decimal (BCD) event/time counter for the reaction-timer datapath.
- Counts qualified enable pulses through an optional built-in prescaler. Supports up/down counting, parallel load, and wrap or saturate mode at the range limits.
- Drives the 7-segment display path directly and flags range-limit events to the timer control FSM.

Parameters:
- DIGITS, 4, number of BCD digits; counter width is 4*DIGITS bits; legal range 1..8.
- PRESCALE, 1, number of qualified E cycles per count step; legal range 1..65535; 1 means step on every E cycle.
- SATURATE, 0, boundary mode: 0 = wrap at the range limit, 1 = hold at the range limit.

Ports:
- Clock  input  1  rising-edge clock
- Clear  input  1  asynchronous active-high reset
- Init  input  1  synchronous clear of count, prescaler and flags
- E  input  1  count enable
- Up  input  1  direction: 1 = increment, 0 = decrement
- Load  input  1  synchronous parallel load
- LoadVal  input  4*DIGITS  load value; digit 0 is bits [3:0]
- BCD  output  4*DIGITS  registered count; digit k is bits [4k+3:4k]
- Carry  output  1  registered one-cycle pulse on a boundary step (carry or borrow out of the top digit)
- Overflow  output  1  sticky boundary flag
- Zero  output  1  registered; high when all digits are 0

Behaviour:
- Clear=1 (asynchronous, active-high): BCD=0, prescaler=0, Carry=0, Overflow=0, Zero=1.
- Recovery: the first active edge after Clear deasserts acts normally.
- Synchronous priority per rising edge: Init > Load > count step.
- Init=1:
  - Same end state as Clear.
  - Takes effect on the edge; E, Load and Up are ignored that cycle.
- Load=1 (and Init=0):
  - BCD <= LoadVal, with each digit >9 clamped to 9.
  - Prescaler <= 0, Carry <= 0, Overflow <= 0.
  - No count step that cycle, even if E=1.
- Prescaler:
  - Internal counter 0..PRESCALE-1; advances only on cycles with E=1 and no Init/Load.
  - A step is taken on an E=1 cycle where prescaler==PRESCALE-1; prescaler then returns to 0.
  - E=0 holds the prescaler value (no loss of partial count).
- Up step:
  - Digit 0 increments; any digit at 9 goes to 0 and propagates a carry to the next digit.
  - The whole vector updates in one cycle; no ripple visible across cycles.
- Down step:
  - Digit 0 decrements; any digit at 0 goes to 9 and propagates a borrow to the next digit.
- Boundary step: Up step at all-9s, or Down step at all-0s.
  - SATURATE=0: value wraps (all-9s -> 0, 0 -> all-9s); Carry=1 for exactly that cycle; Overflow set.
  - SATURATE=1: value is held at the limit; Carry=1 on every boundary step attempt; Overflow set.
- Carry is 0 on every cycle without a boundary step.
- Overflow stays set until Init, Load or Clear.
- Up may change on any cycle; the direction sampled on the stepping edge applies.
- Zero is registered: it tracks the new BCD value on the same edge.
- Latency: BCD, Carry and Zero reflect a step one clock after the enabling edge's inputs are sampled, i.e. they are visible after that edge.
- Non-BCD digits never appear on BCD: loads are clamped, and steps preserve the BCD encoding.
- Clear asserted mid-prescale or mid-count aborts immediately; no pending step survives.

Test Plan:
- DIGITS=4, PRESCALE=1, SATURATE=0: Load 9998, Up=1, E=1 for 3 cycles -> BCD 9999, 0000 (Carry=1, Overflow=1), 0001 (Carry=0, Overflow still 1).
- Up=1 step at 0199 -> 0200. Up=0 steps at 1000 -> 0999, then 0998. Down at 0000, SATURATE=0 -> 9999 with Carry=1.
- SATURATE=1: Load 9999, Up=1, E=1 for 3 cycles -> BCD holds 9999, Carry=1 on each cycle, Overflow=1. Down from 0000 -> holds 0000, Carry=1, Zero stays 1.
- PRESCALE=10: E=1 for 25 cycles from 0 -> BCD=0002. Drop E for 5 cycles, then E=1 for 5 more -> BCD=0003 exactly on the 30th E cycle.
- Priority: Init and Load and E together -> BCD=0. Load=1, E=1, LoadVal=0xA5F3 -> BCD=9593, no step, Overflow cleared.
- Assert Clear asynchronously mid-cycle while BCD=0457 with prescaler mid-count -> BCD=0 and Zero=1 immediately, before the next edge. After release, PRESCALE full E cycles are needed for the first step.
